// File: rtl/ttpu_sched_pkg.sv
// Shared types and helpers for the systolic array scheduler.
package ttpu_sched_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        ISSUE,
        WAIT,
        CAPTURE,
        DRAIN
    } sched_state_e;

    // Width needed to hold a pair count of 0..max_len.
    function automatic int unsigned len_w(input int unsigned max_len);
        return $clog2(max_len + 1);
    endfunction

endpackage

// File: rtl/sched_result_buffer.sv
// Holds one batch of captured array results and serves the indexed read used while draining.
module sched_result_buffer
    import ttpu_sched_pkg::*;
#(
    parameter  int unsigned WIDTH     = 16,
    parameter  int unsigned NUM_UNITS = 16,
    localparam int unsigned IDX_W     = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_capture,
    input  logic [NUM_UNITS-1:0]       i_mask,
    input  logic [NUM_UNITS*WIDTH-1:0] i_data,
    input  logic [IDX_W-1:0]           i_rd_idx,
    output logic [WIDTH-1:0]           o_rd_data
);

    typedef logic [NUM_UNITS-1:0][WIDTH-1:0] lane_vec_t;

    lane_vec_t r_buf;
    lane_vec_t w_data;

    assign w_data = i_data;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_buf <= '0;
        end else if (i_capture) begin
            for (int i = 0; i < NUM_UNITS; i++) begin
                r_buf[i] <= i_mask[i] ? w_data[i] : '0;
            end
        end
    end

    assign o_rd_data = r_buf[i_rd_idx];

endmodule

// File: rtl/systolic_array_scheduler.sv
// Batches a stream of operand pairs onto a systolic array and streams results back in order.
// Optional WAIT timeout with sticky error is enabled by defining SCHED_TIMEOUT_EN.
module systolic_array_scheduler
    import ttpu_sched_pkg::*;
#(
    parameter  int unsigned WIDTH     = 16,
    parameter  int unsigned NUM_UNITS = 16,
    parameter  int unsigned MAX_LEN   = 256,
    parameter  int unsigned TIMEOUT   = 1024,
    localparam int unsigned LEN_W     = len_w(MAX_LEN)
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_job_valid,
    output logic                       o_job_ready,
    input  logic [LEN_W-1:0]           i_job_len,
    input  logic                       i_op_valid,
    output logic                       o_op_ready,
    input  logic [WIDTH-1:0]           i_op_a,
    input  logic [WIDTH-1:0]           i_op_b,
    output logic                       o_sa_start,
    output logic [NUM_UNITS-1:0]       o_sa_active,
    output logic [NUM_UNITS*WIDTH-1:0] o_sa_a,
    output logic [NUM_UNITS*WIDTH-1:0] o_sa_b,
    input  logic [NUM_UNITS*WIDTH-1:0] i_sa_result,
    input  logic [NUM_UNITS-1:0]       i_sa_ready,
    output logic                       o_res_valid,
    input  logic                       i_res_ready,
    output logic [WIDTH-1:0]           o_res_data,
    output logic                       o_res_last,
    output logic                       o_busy,
    output logic                       o_done,
    output logic                       o_err
);

    localparam int unsigned LANE_W = $clog2(NUM_UNITS + 1);
    localparam int unsigned IDX_W  = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;

    typedef logic [NUM_UNITS-1:0][WIDTH-1:0] lane_vec_t;

    sched_state_e         r_state;
    logic [LEN_W-1:0]     r_rem;
    logic [LANE_W-1:0]    r_lane;
    logic [IDX_W-1:0]     r_idx;
    lane_vec_t            r_a;
    lane_vec_t            r_b;
    logic [NUM_UNITS-1:0] r_sa_active;
    logic                 r_sa_start;
    logic                 r_done;
    logic                 r_wait_first;

    logic [LANE_W-1:0]    w_lane_inc;
    logic [IDX_W-1:0]     w_wr_idx;
    logic [NUM_UNITS-1:0] w_next_mask;
    logic                 w_all_ready;
    logic                 w_idx_at_end;
    logic [LEN_W-1:0]     w_job_len_eff;
    lane_vec_t            w_sa_a;
    lane_vec_t            w_sa_b;

    assign w_lane_inc    = r_lane + LANE_W'(1);
    assign w_wr_idx      = r_lane[IDX_W-1:0];
    assign w_all_ready   = ((i_sa_ready & r_sa_active) == r_sa_active);
    assign w_idx_at_end  = ((LANE_W'(r_idx) + LANE_W'(1)) == r_lane);
    assign w_job_len_eff = (i_job_len == '0) ? LEN_W'(1) : i_job_len;

    always_comb begin
        w_next_mask = '0;
        for (int i = 0; i < NUM_UNITS; i++) begin
            w_next_mask[i] = (LANE_W'(i) < w_lane_inc);
        end
    end

    // Lanes outside the active mask are forced to zero towards the array.
    always_comb begin
        w_sa_a = '0;
        w_sa_b = '0;
        for (int i = 0; i < NUM_UNITS; i++) begin
            w_sa_a[i] = r_sa_active[i] ? r_a[i] : '0;
            w_sa_b[i] = r_sa_active[i] ? r_b[i] : '0;
        end
    end

`ifdef SCHED_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TIMEOUT + 1);
    logic [TO_W-1:0] r_wait_cnt;
    logic            r_err;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= IDLE;
            r_rem        <= '0;
            r_lane       <= '0;
            r_idx        <= '0;
            r_a          <= '0;
            r_b          <= '0;
            r_sa_active  <= '0;
            r_sa_start   <= 1'b0;
            r_done       <= 1'b0;
            r_wait_first <= 1'b0;
`ifdef SCHED_TIMEOUT_EN
            r_wait_cnt   <= '0;
            r_err        <= 1'b0;
`endif
        end else begin
            r_sa_start <= 1'b0;
            r_done     <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (i_job_valid) begin
                        r_rem   <= w_job_len_eff;
                        r_lane  <= '0;
                        r_state <= LOAD;
                    end
                end
                LOAD: begin
                    if (i_op_valid) begin
                        r_a[w_wr_idx] <= i_op_a;
                        r_b[w_wr_idx] <= i_op_b;
                        r_lane        <= w_lane_inc;
                        r_rem         <= r_rem - LEN_W'(1);
                        if (w_lane_inc == LANE_W'(NUM_UNITS) || r_rem == LEN_W'(1)) begin
                            r_state     <= ISSUE;
                            r_sa_start  <= 1'b1;
                            r_sa_active <= w_next_mask;
                        end
                    end
                end
                ISSUE: begin
                    r_state      <= WAIT;
                    r_wait_first <= 1'b1;
`ifdef SCHED_TIMEOUT_EN
                    r_wait_cnt   <= '0;
`endif
                end
                WAIT: begin
                    // Array ready is stale on the first WAIT cycle, so it is not trusted.
                    r_wait_first <= 1'b0;
                    if (!r_wait_first && w_all_ready) begin
                        r_state <= CAPTURE;
`ifdef SCHED_TIMEOUT_EN
                    end else if (r_wait_cnt == TO_W'(TIMEOUT - 1)) begin
                        r_err       <= 1'b1;
                        r_sa_active <= '0;
                        r_state     <= IDLE;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + TO_W'(1);
`endif
                    end
                end
                CAPTURE: begin
                    r_idx       <= '0;
                    r_sa_active <= '0;
                    r_state     <= DRAIN;
                end
                DRAIN: begin
                    if (i_res_ready) begin
                        if (w_idx_at_end) begin
                            r_idx <= '0;
                            if (r_rem != '0) begin
                                r_lane  <= '0;
                                r_state <= LOAD;
                            end else begin
                                r_done  <= 1'b1;
                                r_state <= IDLE;
                            end
                        end else begin
                            r_idx <= r_idx + IDX_W'(1);
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    sched_result_buffer #(
        .WIDTH     (WIDTH),
        .NUM_UNITS (NUM_UNITS)
    ) u_result_buffer (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_capture (r_state == CAPTURE),
        .i_mask    (r_sa_active),
        .i_data    (i_sa_result),
        .i_rd_idx  (r_idx),
        .o_rd_data (o_res_data)
    );

    assign o_job_ready = (r_state == IDLE);
    assign o_op_ready  = (r_state == LOAD);
    assign o_busy      = (r_state != IDLE);
    assign o_res_valid = (r_state == DRAIN);
    assign o_res_last  = (r_state == DRAIN) && (r_rem == '0) && w_idx_at_end;
    assign o_sa_start  = r_sa_start;
    assign o_sa_active = r_sa_active;
    assign o_sa_a      = w_sa_a;
    assign o_sa_b      = w_sa_b;
    assign o_done      = r_done;

`ifdef SCHED_TIMEOUT_EN
    assign o_err = r_err;
`else
    assign o_err = 1'b0;
`endif

endmodule
